sine_pwm_seq: RTL
=================

SINE_PWM_SEQ -- requirements
Module: sine_pwm_seq

Interface
Parameters:
REQ-001 PERIOD, default 1000, clk cycles per PWM period (minimum 4).
REQ-002 PHASE_W, default 16, phase accumulator width.
REQ-003 ADDR_W, default 10, sample-table address width (ADDR_W <= PHASE_W).
REQ-004 WIDTH_W, default 32, duty-width word width.
REQ-005 STEP_RST, default 1, phase step loaded at reset.

Ports:
REQ-006 clk  in  1  single clock; all logic on posedge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  single-cycle pulse; begin sequencing.
REQ-009 stop  in  1  single-cycle pulse; finish the current period, then idle.
REQ-010 cfg_valid  in  1  new phase step offered.
REQ-011 cfg_step  in  PHASE_W  phase increment per PWM period.
REQ-012 cfg_ready  out  1  cfg_step accepted on a cycle with cfg_valid && cfg_ready.
REQ-013 samp_addr  out  ADDR_W  sample-table address.
REQ-014 samp_rd  out  1  sample read strobe; table returns samp_data exactly 1 cycle later.
REQ-015 samp_data  in  WIDTH_W  sample value (duty width in clk cycles).
REQ-016 width  out  WIDTH_W  duty width for the PWM comparator, stable for a whole period.
REQ-017 period_tick  out  1  high on the last cycle of each period (pcnt == PERIOD-1).
REQ-018 busy  out  1  high in RUN or DRAIN.

Function
REQ-019 FSM states: IDLE, RUN, DRAIN.
REQ-020 Period counter pcnt: counts 0..PERIOD-1 and wraps in RUN/DRAIN; held at 0 in IDLE.
REQ-021 IDLE->RUN on start && !stop; pcnt = 0 on the first RUN cycle.
REQ-022 RUN->DRAIN on stop; DRAIN->IDLE on period_tick.
REQ-023 start during RUN/DRAIN is ignored; start and stop in the same cycle in IDLE are ignored (stop wins).
REQ-024 In RUN only, samp_rd pulses when pcnt == PERIOD-3, with samp_addr = phase[PHASE_W-1 -: ADDR_W].
REQ-025 On the cycle after samp_rd, samp_data is captured into width_nxt, clamped: width_nxt = min(samp_data, PERIOD).
REQ-026 At period_tick in RUN: width <= width_nxt and phase <= phase + step (mod 2^PHASE_W, wrap silently).
REQ-027 At period_tick in DRAIN: width <= 0; phase is held.
REQ-028 The first RUN period outputs the width already present (0 after reset); the sample for phase 0 appears on the second period (1-period latency).
REQ-029 cfg handshake: cfg_ready = !cfg_pend. Accepting loads cfg_buf and sets cfg_pend.
REQ-030 In IDLE, a pending cfg is applied to step on the next cycle. In RUN/DRAIN it is applied at period_tick, after that tick's phase update uses the old step.
REQ-031 samp_addr holds its last value when samp_rd is low; samp_rd is never asserted in IDLE or DRAIN.

Reset
REQ-032 rst_n low asynchronously forces state IDLE, pcnt 0, phase 0, step STEP_RST, width 0, width_nxt 0, cfg_pend 0, samp_rd 0, samp_addr 0, period_tick 0, busy 0.
REQ-033 Reset mid-period aborts immediately with no drain. After release the block waits in IDLE for start.

Structure
REQ-034 A shared package sine_pwm_pkg holds the FSM state encoding and the default PERIOD/PHASE_W/ADDR_W/WIDTH_W constants.
REQ-035 One sub-module, pwm_period_cnt (period counter with tick output), is instantiated. The FSM, phase accumulator and config buffer stay in sine_pwm_seq.

Verification
REQ-036 PERIOD=8, step=1, ROM data = addr: start -> period_tick every 8 cycles; width is 0 in the first period, then samp_data of addr 0, then addr 1 (after shift), each held 8 cycles.
REQ-037 ROM returns 5000 with PERIOD=1000 -> width = 1000 at the next boundary.
REQ-038 stop mid-period -> busy stays 1 until period_tick; then width=0, state IDLE, and no samp_rd during DRAIN.
REQ-039 cfg_valid with step=0x4000 during RUN -> cfg_ready drops for 1+ cycle and the new step takes effect from the period after the next tick; a second cfg_valid while pending is not accepted until that tick.
REQ-040 phase=0xFFFF, step=2 -> phase becomes 0x0001 after the tick, with no error.
REQ-041 rst_n low at pcnt=5 -> all outputs zero asynchronously; start together with stop after release -> stays IDLE.

Source files
------------

// File: rtl/sine_pwm_pkg.sv
// Shared definitions for the sine-modulated PWM sequencer.
//   - state_t     : sequencer FSM encoding (IDLE / RUN / DRAIN)
//   - *_DEF       : default parameter values used by sine_pwm_seq
package sine_pwm_pkg;

    localparam int PERIOD_DEF  = 1000;
    localparam int PHASE_W_DEF = 16;
    localparam int ADDR_W_DEF  = 10;
    localparam int WIDTH_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_period_cnt.sv
// PWM period counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count enable; while low the counter is held at 0
//   pcnt       : position within the period, 0 .. PERIOD-1
//   tick       : high on the last cycle of each period (enabled only)
module pwm_period_cnt #(
    parameter int PERIOD = 1000,
    parameter int CNT_W  = $clog2(PERIOD)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] pcnt,
    output logic             tick
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    assign tick = en && (pcnt == LAST);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (!en || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/sine_pwm_seq.sv
// Sine-modulated PWM sequencer.
// Once per PWM period a duty width is fetched from an external sample table
// addressed by the top bits of a phase accumulator; the width is presented to
// a PWM comparator and held for a full period. The phase advances by a
// configurable step at every period boundary.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start / stop     : single-cycle pulses; stop finishes the current period
//   cfg_valid/_ready : phase-step handshake, cfg_step is the new increment
//   samp_addr/_rd    : table address and read strobe (data 1 cycle later)
//   samp_data        : table data, duty width in clk cycles
//   width            : duty width for the comparator
//   period_tick      : last cycle of each period
//   busy             : sequencer in RUN or DRAIN
module sine_pwm_seq
    import sine_pwm_pkg::*;
#(
    parameter int          PERIOD   = PERIOD_DEF,
    parameter int          PHASE_W  = PHASE_W_DEF,
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int          WIDTH_W  = WIDTH_W_DEF,
    parameter int unsigned STEP_RST = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               cfg_valid,
    input  logic [PHASE_W-1:0] cfg_step,
    output logic               cfg_ready,
    output logic [ADDR_W-1:0]  samp_addr,
    output logic               samp_rd,
    input  logic [WIDTH_W-1:0] samp_data,
    output logic [WIDTH_W-1:0] width,
    output logic               period_tick,
    output logic               busy
);
    localparam int                 CNT_W     = $clog2(PERIOD);
    // Reading at PERIOD-3 leaves one cycle for the table and one for the
    // clamp register before the boundary at PERIOD-1.
    localparam logic [CNT_W-1:0]   RD_CNT    = CNT_W'(PERIOD - 3);
    localparam logic [WIDTH_W-1:0] WIDTH_MAX = WIDTH_W'(PERIOD);

    state_t               state;
    state_t               next_state;
    logic [CNT_W-1:0]     pcnt;
    logic [PHASE_W-1:0]   phase;
    logic [PHASE_W-1:0]   step;
    logic [PHASE_W-1:0]   cfg_buf;
    logic                 cfg_pend;
    logic [ADDR_W-1:0]    addr_q;
    logic                 rd_d;
    logic [WIDTH_W-1:0]   width_nxt;

    pwm_period_cnt #(
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) u_period_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (busy),
        .pcnt (pcnt),
        .tick (period_tick)
    );

    assign busy      = (state != ST_IDLE);
    assign cfg_ready = !cfg_pend;
    assign samp_rd   = (state == ST_RUN) && (pcnt == RD_CNT);
    // The address follows the phase only while reading; otherwise the last
    // issued address is held for the table.
    assign samp_addr = samp_rd ? phase[PHASE_W-1 -: ADDR_W] : addr_q;

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:  if (start && !stop) next_state = ST_RUN;
            ST_RUN:   if (stop)           next_state = ST_DRAIN;
            ST_DRAIN: if (period_tick)    next_state = ST_IDLE;
            default:                      next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Sample fetch: remember the issued address and clamp the returned width
    // to the period so the comparator can never be asked for more than 100 %.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            rd_d      <= 1'b0;
            width_nxt <= '0;
        end else begin
            rd_d <= samp_rd;
            if (samp_rd) begin
                addr_q <= samp_addr;
            end
            if (rd_d) begin
                width_nxt <= (samp_data > WIDTH_MAX) ? WIDTH_MAX : samp_data;
            end
        end
    end

    // Period boundary: RUN publishes the fetched width and advances the phase;
    // DRAIN zeroes the output and leaves the phase where it stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width <= '0;
            phase <= '0;
        end else if (period_tick) begin
            if (state == ST_RUN) begin
                width <= width_nxt;
                phase <= phase + step;
            end else begin
                width <= '0;
            end
        end
    end

    // Config buffer. While sequencing, a new step is swapped in on the tick,
    // so that tick's phase update still uses the old step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step     <= PHASE_W'(STEP_RST);
            cfg_buf  <= '0;
            cfg_pend <= 1'b0;
        end else if (cfg_pend) begin
            if ((state == ST_IDLE) || period_tick) begin
                step     <= cfg_buf;
                cfg_pend <= 1'b0;
            end
        end else if (cfg_valid) begin
            cfg_buf  <= cfg_step;
            cfg_pend <= 1'b1;
        end
    end

endmodule
